// File: rtl/instr_sequencer_if.sv
// Instruction-memory read channel between the sequencer (master) and memory (slave).
interface instr_sequencer_if #(
    parameter int unsigned PC_WIDTH = 8
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic                imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback controller: fetches over req/ack,
// times the EXEC window, pulses the register-file write and stops on HALT.
module instr_sequencer #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    instr_sequencer_if.master   imem,
    output logic [31:0]         instruction,
    output logic                reg_write_en,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         retired,
    output logic                busy,
    output logic                halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    logic [2:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [31:0]         r_instr;
    logic [15:0]         r_retired;
    logic [3:0]          r_exec_cnt;
    logic                w_is_halt;

    assign w_is_halt = (r_instr[31:24] == HALT_OPCODE);

    // Outputs decode straight from the state register, so reset clears them immediately.
    assign imem.imem_req  = (r_state == S_FETCH);
    assign imem.imem_addr = r_pc;
    assign instruction    = r_instr;
    assign reg_write_en   = (r_state == S_WB);
    assign pc             = r_pc;
    assign retired        = r_retired;
    assign busy           = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                            (r_state == S_EXEC)  || (r_state == S_WB);
    assign halted         = (r_state == S_HALTED);

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_instr    <= '0;
            r_retired  <= '0;
            r_exec_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        r_pc      <= '0;
                        r_retired <= '0;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem.imem_ack) begin
                        r_instr <= imem.imem_rdata;
                        r_pc    <= r_pc + PC_WIDTH'(1);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_is_halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        r_exec_cnt <= EXEC_LOAD;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_exec_cnt != 4'd0) begin
                        r_exec_cnt <= r_exec_cnt - 4'd1;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_retired <= r_retired + 16'd1;
                    r_state   <= stop ? S_IDLE : S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: one default instance and one with a
// 2-bit PC and 3-cycle EXEC window, each fed by a small memory model.
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, start_a, stop_a;
    logic        ack_en_a, ack_force_a;
    logic [31:0] mem_a [256];
    logic [31:0] instr_a;
    logic        rwe_a, busy_a, halted_a;
    logic [7:0]  pc_a;
    logic [15:0] retired_a;

    logic        reset_b, start_b;
    logic [31:0] mem_b [4];
    logic [31:0] instr_b;
    logic        rwe_b, busy_b, halted_b;
    logic [1:0]  pc_b;
    logic [15:0] retired_b;

    instr_sequencer_if #(.PC_WIDTH(8)) if_a ();
    instr_sequencer_if #(.PC_WIDTH(2)) if_b ();

    assign if_a.imem_ack   = ack_force_a | (if_a.imem_req & ack_en_a);
    assign if_a.imem_rdata = mem_a[if_a.imem_addr];
    assign if_b.imem_ack   = if_b.imem_req;
    assign if_b.imem_rdata = mem_b[if_b.imem_addr];

    instr_sequencer #(.PC_WIDTH(8), .EXEC_CYCLES(1), .HALT_OPCODE(8'hFF)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .stop(stop_a), .imem(if_a),
        .instruction(instr_a), .reg_write_en(rwe_a), .pc(pc_a), .retired(retired_a),
        .busy(busy_a), .halted(halted_a)
    );

    instr_sequencer #(.PC_WIDTH(2), .EXEC_CYCLES(3), .HALT_OPCODE(8'hFF)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .stop(1'b0), .imem(if_b),
        .instruction(instr_b), .reg_write_en(rwe_b), .pc(pc_b), .retired(retired_b),
        .busy(busy_b), .halted(halted_b)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        int last_wb;
        int ph;
        int k;

        reset_a = 1'b1; start_a = 1'b0; stop_a = 1'b0;
        ack_en_a = 1'b1; ack_force_a = 1'b0;
        reset_b = 1'b1; start_b = 1'b0;
        for (int i = 0; i < 256; i++) mem_a[i] = 32'h0;
        mem_a[0] = 32'h08020005; mem_a[1] = 32'h09000102;
        mem_a[2] = 32'h00000304; mem_a[3] = 32'hFF000000;
        mem_b[0] = 32'h11111111; mem_b[1] = 32'h22222222;
        mem_b[2] = 32'h33333333; mem_b[3] = 32'h44444444;

        tick(); tick();
        check("rst_req",     if_a.imem_req, 0);
        check("rst_busy",    busy_a, 0);
        check("rst_halted",  halted_a, 0);
        check("rst_rwe",     rwe_a, 0);
        check("rst_pc",      pc_a, 0);
        check("rst_instr",   instr_a, 0);
        check("rst_retired", retired_a, 0);
        reset_a = 1'b0; reset_b = 1'b0;
        tick();
        check("idle_hold_req", if_a.imem_req, 0);

        // First instruction with zero-wait memory: FETCH, DECODE, EXEC, WB.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t1_fetch_req",  if_a.imem_req, 1);
        check("t1_fetch_addr", if_a.imem_addr, 0);
        check("t1_fetch_busy", busy_a, 1);
        tick();
        check("t1_dec_instr", instr_a, 32'h08020005);
        check("t1_dec_pc",    pc_a, 1);
        check("t1_dec_rwe",   rwe_a, 0);
        tick();
        check("t1_exec_rwe", rwe_a, 0);
        tick();
        check("t1_wb_rwe",     rwe_a, 1);
        check("t1_wb_retired", retired_a, 0);
        tick();
        check("t1_next_rwe",     rwe_a, 0);
        check("t1_next_retired", retired_a, 1);
        check("t1_next_addr",    if_a.imem_addr, 1);

        // Second instruction, then a 3-cycle stall on the fetch at address 2.
        tick(); tick(); tick();
        check("t2_wb_rwe", rwe_a, 1);
        ack_en_a = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_stall_req",   if_a.imem_req, 1);
            check("t2_stall_addr",  if_a.imem_addr, 2);
            check("t2_stall_rwe",   rwe_a, 0);
            check("t2_stall_instr", instr_a, 32'h09000102);
            if (i == 3) ack_en_a = 1'b1;
            tick();
        end
        check("t2_ack_instr", instr_a, 32'h00000304);
        check("t2_ack_pc",    pc_a, 3);
        tick(); tick(); tick(); tick(); tick();
        check("t2_halt",    halted_a, 1);
        check("t2_busy",    busy_a, 0);
        check("t2_pc",      pc_a, 4);
        check("t2_retired", retired_a, 3);

        // Restart from HALTED with a three-word program ending in HALT.
        mem_a[0] = 32'h09000102; mem_a[1] = 32'h00000304;
        mem_a[2] = 32'hFF000000; mem_a[3] = 32'h12345678;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t3_restart_addr",    if_a.imem_addr, 0);
        check("t3_restart_retired", retired_a, 0);
        pulses = 0;
        for (int i = 0; i < 40 && !halted_a; i++) begin
            tick();
            if (rwe_a) pulses++;
        end
        check("t3_pulses",  pulses, 2);
        check("t3_halted",  halted_a, 1);
        check("t3_busy",    busy_a, 0);
        check("t3_pc",      pc_a, 3);
        check("t3_retired", retired_a, 2);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("t3_again_req",     if_a.imem_req, 1);
        check("t3_again_addr",    if_a.imem_addr, 0);
        check("t3_again_retired", retired_a, 0);

        // stop (with start) during WB returns to IDLE.
        tick(); tick(); tick();
        check("t4_wb_rwe", rwe_a, 1);
        stop_a = 1'b1; start_a = 1'b1;
        tick();
        stop_a = 1'b0; start_a = 1'b0;
        check("t4_idle_busy",    busy_a, 0);
        check("t4_idle_pc",      pc_a, 1);
        check("t4_idle_retired", retired_a, 1);
        tick(); tick(); tick();
        check("t4_idle_req", if_a.imem_req, 0);

        // stop outside WB is not remembered.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        tick();
        check("t4b_wb_rwe", rwe_a, 1);
        tick();
        check("t4b_fetch_req",  if_a.imem_req, 1);
        check("t4b_fetch_addr", if_a.imem_addr, 1);

        // Asynchronous reset in the middle of a stalled fetch.
        ack_en_a = 1'b0;
        tick();
        check("t5_pre_req", if_a.imem_req, 1);
        #2 reset_a = 1'b1;
        #1;
        check("t5_async_req",     if_a.imem_req, 0);
        check("t5_async_pc",      pc_a, 0);
        check("t5_async_busy",    busy_a, 0);
        check("t5_async_instr",   instr_a, 0);
        check("t5_async_retired", retired_a, 0);
        tick();
        reset_a = 1'b0;
        ack_force_a = 1'b1;
        tick(); tick();
        ack_force_a = 1'b0;
        check("t5_late_instr", instr_a, 0);
        check("t5_late_busy",  busy_a, 0);
        check("t5_late_req",   if_a.imem_req, 0);

        // Narrow PC wrap and EXEC_CYCLES=3 timing: each instruction spans 6 cycles.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        last_wb = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            ph = cyc % 6;
            k  = cyc / 6;
            check("b_rwe", rwe_b, (ph == 5) ? 32'd1 : 32'd0);
            if (ph == 0) begin
                check("b_fetch_addr", if_b.imem_addr, k % 4);
            end else begin
                check("b_instr", instr_b, mem_b[k % 4]);
                check("b_pc", pc_b, (k + 1) % 4);
            end
            if (rwe_b) begin
                if (last_wb >= 0) check("b_spacing", cyc - last_wb, 6);
                last_wb = cyc;
            end
            tick();
        end
        check("b_retired", retired_b, 5);
        check("b_last_wb", last_wb, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
